// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues req/ack ROM fetches and feeds the IF/ID register.
// A one-entry skid absorbs the fetch that completes while ID is stalled; redirects discard fetches.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_rom_req,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic              i_rom_ack,
  input  logic [INST_W-1:0] i_rom_inst,
  input  logic              i_stall,
  input  logic              i_branch_en,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;

  logic              ack;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] target;

  // A response only counts while a request is actually outstanding.
  assign ack      = i_rom_ack & o_rom_req;
  assign addr_inc = o_rom_addr + ADDR_W'(4);
  assign target   = {i_branch_target[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      skid_pc    <= '0;
      skid_inst  <= '0;
      o_rom_req  <= 1'b0;
      o_rom_addr <= '0;
      if_pc      <= '0;
      if_inst    <= '0;
      if_valid   <= 1'b0;
    end else if (i_branch_en) begin
      pc        <= target;
      if_valid  <= 1'b0;
      skid_pc   <= '0;
      skid_inst <= '0;
      // An unacked request must finish at its old address before the target can be issued.
      if ((state == REQ || state == DROP) && !ack) begin
        state <= DROP;
      end else begin
        state      <= REQ;
        o_rom_req  <= 1'b1;
        o_rom_addr <= target;
      end
    end else begin
      case (state)
        IDLE: begin
          state      <= REQ;
          o_rom_req  <= 1'b1;
          o_rom_addr <= pc;
        end
        REQ: begin
          if (i_stall) begin
            if (ack) begin
              skid_pc   <= o_rom_addr;
              skid_inst <= i_rom_inst;
              pc        <= addr_inc;
              o_rom_req <= 1'b0;
              state     <= HOLD;
            end
          end else if (ack) begin
            if_pc      <= o_rom_addr;
            if_inst    <= i_rom_inst;
            if_valid   <= 1'b1;
            pc         <= addr_inc;
            o_rom_addr <= addr_inc;
          end else begin
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!i_stall) begin
            if_pc      <= skid_pc;
            if_inst    <= skid_inst;
            if_valid   <= 1'b1;
            skid_pc    <= '0;
            skid_inst  <= '0;
            state      <= REQ;
            o_rom_req  <= 1'b1;
            o_rom_addr <= pc;
          end
        end
        DROP: begin
          if (ack) begin
            state      <= REQ;
            o_rom_addr <= pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic, all checked against a
// transaction-level fetch model (fetch pointer, open request record, skid queue).
module tb_inst_fetch;

  localparam logic [31:0] ROM_KEY = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_req, rom_ack = 1'b0;
  logic [31:0] rom_addr, rom_inst;
  logic        stall = 1'b0, br = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] f_pc, f_inst;
  logic        f_valid;

  logic        d2_req, d2_valid;
  logic [31:0] d2_addr, d2_inst_in, d2_pc, d2_inst;
  logic        tie0 = 1'b0, tie1 = 1'b1;
  logic [31:0] tie0_w = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ ROM_KEY;
  endfunction

  assign rom_inst   = rom_word(rom_addr);
  assign d2_inst_in = rom_word(d2_addr);

  inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .o_rom_req(rom_req), .o_rom_addr(rom_addr),
    .i_rom_ack(rom_ack), .i_rom_inst(rom_inst),
    .i_stall(stall), .i_branch_en(br), .i_branch_target(tgt),
    .if_pc(f_pc), .if_inst(f_inst), .if_valid(f_valid)
  );

  // Second instance: zero-wait ROM, no stall/branch, start address near the top of the space.
  inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'hFFFFFFF8)) dut_wrap (
    .clk(clk), .rst(rst),
    .o_rom_req(d2_req), .o_rom_addr(d2_addr),
    .i_rom_ack(tie1), .i_rom_inst(d2_inst_in),
    .i_stall(tie0), .i_branch_en(tie0), .i_branch_target(tie0_w),
    .if_pc(d2_pc), .if_inst(d2_inst), .if_valid(d2_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: what has been fetched, what is in flight, and what is waiting for ID.
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_skid[$];
  logic [31:0] m_fetch_ptr, m_req_addr, m_pres_pc, m_pres_inst;
  logic        m_req_open, m_doomed, m_boot, m_pres_valid;

  task automatic model_reset(input logic [31:0] start);
    m_skid.delete();
    m_fetch_ptr = start; m_req_addr = '0; m_req_open = 1'b0; m_doomed = 1'b0;
    m_boot = 1'b1; m_pres_valid = 1'b0; m_pres_pc = '0; m_pres_inst = '0;
  endtask

  task automatic open_req(input logic [31:0] a);
    m_req_open = 1'b1; m_req_addr = a; m_doomed = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic b, input logic [31:0] t,
                            input logic s, input logic a_in);
    logic a;
    ent_t e;
    a = a_in && m_req_open;
    if (r) begin
      model_reset(32'h0);
    end else if (b) begin
      m_pres_valid = 1'b0;
      m_skid.delete();
      m_fetch_ptr = t & 32'hFFFFFFFC;
      m_boot = 1'b0;
      if (m_req_open && !a) m_doomed = 1'b1;
      else open_req(m_fetch_ptr);
    end else if (m_boot) begin
      m_boot = 1'b0;
      open_req(m_fetch_ptr);
    end else if (m_req_open && m_doomed) begin
      if (a) open_req(m_fetch_ptr);
    end else if (s) begin
      if (a) begin
        e.pc = m_req_addr; e.inst = rom_word(m_req_addr);
        m_skid.push_back(e);
        m_fetch_ptr = m_req_addr + 32'd4;
        m_req_open = 1'b0;
      end
    end else if (m_skid.size() != 0) begin
      e = m_skid.pop_front();
      m_pres_valid = 1'b1; m_pres_pc = e.pc; m_pres_inst = e.inst;
      open_req(m_fetch_ptr);
    end else if (a) begin
      m_pres_valid = 1'b1; m_pres_pc = m_req_addr; m_pres_inst = rom_word(m_req_addr);
      m_fetch_ptr = m_req_addr + 32'd4;
      open_req(m_fetch_ptr);
    end else begin
      m_pres_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic r, input logic b, input logic [31:0] t,
                       input logic s, input logic a);
    @(negedge clk);
    rst = r; br = b; tgt = t; stall = s; rom_ack = a;
    model_step(r, b, t, s, a);
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d rst=%b br=%b stall=%b ack=%b | req=%b addr=%h valid=%b pc=%h inst=%h",
             cyc, r, b, s, a, rom_req, rom_addr, f_valid, f_pc, f_inst);
    chk("rom_req", 32'(rom_req), 32'(m_req_open));
    if (m_req_open) chk("rom_addr", rom_addr, m_req_addr);
    chk("if_valid", 32'(f_valid), 32'(m_pres_valid));
    if (m_pres_valid) begin
      chk("if_pc", f_pc, m_pres_pc);
      chk("if_inst", f_inst, m_pres_inst);
    end
  endtask

  initial begin
    int k;
    int n;
    model_reset(32'h0);

    // Reset and first request, with the zero-wait stream on both instances.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_addr", rom_addr, 32'd0);
    chk("rst_pc", f_pc, 32'd0);
    chk("rst_inst", f_inst, 32'd0);
    chk("rst_valid", 32'(f_valid), 32'd0);
    chk("rst_wrap_valid", 32'(d2_valid), 32'd0);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 1);
      if (i == 0) begin
        chk("first_req", 32'(rom_req), 32'd1);
        chk("first_addr", rom_addr, 32'd0);
      end
      if (d2_valid) begin
        chk("wrap_pc", d2_pc, 32'hFFFFFFF8 + 32'(4 * k));
        chk("wrap_inst", d2_inst, rom_word(32'hFFFFFFF8 + 32'(4 * k)));
        k++;
      end
    end
    chk("wrap_count", 32'(k), 32'd7);

    // Stall while 0x8 is presented: 0xC lands in the skid, then drains in order.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    chk("pre_stall_pc", f_pc, 32'h8);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1);
    chk("stall_hold_pc", f_pc, 32'h8);
    chk("stall_req", 32'(rom_req), 32'd0);
    cycle(0, 0, 0, 0, 1);
    chk("skid_pc", f_pc, 32'hC);
    cycle(0, 0, 0, 0, 1);
    chk("after_skid_pc", f_pc, 32'h10);

    // Slow ROM with a redirect behind the request for 0x20.
    n = 0;
    while (!(rom_req && rom_addr == 32'h20) && n < 40) begin
      cycle(0, 0, 0, 0, 1);
      n++;
    end
    chk("reach_0x20", rom_addr, 32'h20);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 32'h100, 0, 0);
    chk("drop_addr", rom_addr, 32'h20);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("drop_valid", 32'(f_valid), 32'd0);
    chk("redirect_addr", rom_addr, 32'h100);
    cycle(0, 0, 0, 0, 1);
    chk("redirect_pc", f_pc, 32'h100);

    // Branch, stall and ack in the same cycle: the branch wins.
    cycle(0, 1, 32'h200, 1, 1);
    chk("bsa_valid", 32'(f_valid), 32'd0);
    chk("bsa_addr", rom_addr, 32'h200);
    cycle(0, 0, 0, 0, 1);
    chk("bsa_next_pc", f_pc, 32'h200);
    chk("bsa_next_valid", 32'(f_valid), 32'd1);

    // Randomized traffic, including unaligned targets and occasional mid-run resets.
    for (int i = 0; i < 1500; i++) begin
      logic r, b, s, a;
      logic [31:0] t;
      r = ($urandom_range(0, 199) == 0);
      b = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 9) < 3);
      a = ($urandom_range(0, 9) < 6);
      t = $urandom & 32'h0000_0FFF;
      cycle(r, b, t, s, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
